// File: rtl/hub75_pkg.sv
// Shared definitions for the HUB75 frame buffer write-side blocks:
// the feeder FSM state encoding and an address-width helper.
package hub75_pkg;

  typedef enum logic [2:0] {
    FILL     = 3'd0,
    WAIT_RDY = 3'd1,
    SETTLE   = 3'd2,
    FLUSH    = 3'd3,
    FSWAP    = 3'd4
  } fb_state_e;

  // Index width for a power-of-2 count; never narrower than one bit
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hub75_fb_feeder.sv
// Raster pixel stream to HUB75 frame buffer write port. Writes each line
// into the row buffer, then requests row swap+store, and after the last
// line waits for the final store to drain before swapping frames.
module hub75_fb_feeder
  import hub75_pkg::*;
#(
  parameter int N_BANKS     = 2,
  parameter int N_ROWS      = 32,
  parameter int N_COLS      = 64,
  parameter int BITDEPTH    = 24,
  parameter int LOG_N_BANKS = addr_w(N_BANKS),
  parameter int LOG_N_ROWS  = addr_w(N_ROWS),
  parameter int LOG_N_COLS  = addr_w(N_COLS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BITDEPTH-1:0]    in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  output logic [LOG_N_BANKS-1:0] wr_bank_addr,
  output logic [LOG_N_ROWS-1:0]  wr_row_addr,
  output logic                   wr_row_store,
  input  logic                   wr_row_rdy,
  output logic                   wr_row_swap,
  output logic [BITDEPTH-1:0]    wr_data,
  output logic [LOG_N_COLS-1:0]  wr_col_addr,
  output logic                   wr_en,
  output logic                   frame_swap,
  output logic                   frame_done,
  output logic                   sof_err
);

  localparam int LINE_W = LOG_N_BANKS + LOG_N_ROWS;
  localparam logic [LOG_N_COLS-1:0] COL_LAST  = LOG_N_COLS'(N_COLS - 1);
  localparam logic [LINE_W-1:0]     LINE_LAST = LINE_W'(N_BANKS * N_ROWS - 1);

  fb_state_e               state, state_nxt;
  logic [LOG_N_COLS-1:0]   col;
  logic [LINE_W-1:0]       line;
  logic                    accept, resync, line_end, row_go;

  assign accept   = in_valid & in_ready;
  // SOF away from the frame origin restarts the frame at this pixel
  assign resync   = accept & in_sof & ((col != '0) | (line != '0));
  assign line_end = accept & ~resync & (col == COL_LAST);
  // Row handoff waits for the last row-buffer write to land
  assign row_go   = (state == WAIT_RDY) & ~wr_en & wr_row_rdy;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:     if (line_end) state_nxt = WAIT_RDY;
      WAIT_RDY: if (row_go)   state_nxt = (line == LINE_LAST) ? SETTLE : FILL;
      SETTLE:                 state_nxt = FLUSH;
      FLUSH:    if (wr_row_rdy) state_nxt = FSWAP;
      FSWAP:                  state_nxt = FILL;
      default:                state_nxt = FILL;
    endcase
  end

  // Handshake pulses decoded from state; held low whenever reset is asserted
  always_comb begin
    wr_row_swap  = 1'b0;
    wr_row_store = 1'b0;
    frame_swap   = 1'b0;
    frame_done   = 1'b0;
    if (rst_n) begin
      wr_row_swap  = row_go;
      wr_row_store = row_go;
      frame_swap   = (state == FSWAP);
      frame_done   = (state == FSWAP);
    end
  end

  // Column/line position of the next accepted pixel
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col  <= '0;
      line <= '0;
    end else if (resync) begin
      col  <= LOG_N_COLS'(1);
      line <= '0;
    end else begin
      if (accept) col  <= col + LOG_N_COLS'(1);
      if (row_go) line <= line + LINE_W'(1);
    end
  end

  // Registered write port, ready and line address capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready     <= 1'b0;
      wr_en        <= 1'b0;
      sof_err      <= 1'b0;
      wr_data      <= '0;
      wr_col_addr  <= '0;
      wr_bank_addr <= '0;
      wr_row_addr  <= '0;
    end else begin
      in_ready <= (state_nxt == FILL);
      wr_en    <= accept;
      sof_err  <= resync;
      if (accept) begin
        wr_data     <= in_data;
        wr_col_addr <= resync ? '0 : col;
      end
      // Address is latched with the last pixel so it is stable for the store
      if (line_end) begin
        wr_bank_addr <= line[LINE_W-1 -: LOG_N_BANKS];
        wr_row_addr  <= line[LOG_N_ROWS-1:0];
      end
    end
  end

endmodule

// File: tb/tb_hub75_fb_feeder.sv
// Bench for hub75_fb_feeder: scenario table with expected event counts,
// hand sequences for reset/back-pressure, and a queue-based reference
// model checking every write, store and frame swap cycle by cycle.
module tb_hub75_fb_feeder;

  localparam int NB = 2, NR = 4, NC = 8, BD = 16, NL = NB * NR;

  logic          clk = 1'b0;
  logic          rst_n, in_valid, in_ready, in_sof;
  logic [BD-1:0] in_data, wr_data;
  logic [0:0]    wr_bank_addr;
  logic [1:0]    wr_row_addr;
  logic [2:0]    wr_col_addr;
  logic          wr_row_store, wr_row_rdy, wr_row_swap, wr_en;
  logic          frame_swap, frame_done, sof_err;

  always #5 clk = ~clk;

  hub75_fb_feeder #(.N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .BITDEPTH(BD)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .in_sof(in_sof), .wr_bank_addr(wr_bank_addr),
    .wr_row_addr(wr_row_addr), .wr_row_store(wr_row_store),
    .wr_row_rdy(wr_row_rdy), .wr_row_swap(wr_row_swap), .wr_data(wr_data),
    .wr_col_addr(wr_col_addr), .wr_en(wr_en), .frame_swap(frame_swap),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  typedef struct { int col; int data; bit err; } wr_t;
  typedef struct { int npix; int sof_a; int sof_b; int pct; int st; int fs; int se; } vec_t;

  wr_t qw[$];   // accepted pixel awaiting its write strobe
  int  qs[$];   // completed lines awaiting store
  int  nchk, nerr, ncyc;
  int  m_col, m_line, phase, busy, rel_cnt, nst, nfs, nse;
  bit  hold, accepted;
  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, exp, ncyc);
    end
  endtask

  // Reference: each accepted pixel is written the next cycle; a completed
  // line is stored once no write is pending and rdy is high; after the last
  // line's store: one settle cycle, then flush until rdy, then frame swap.
  task automatic monitor();
    bit exp_wr, exp_st, exp_fs, exp_ir, err;
    wr_t w;
    int ln;
    accepted = 0;
    exp_wr = qw.size() > 0;
    exp_st = qs.size() > 0 && !exp_wr && wr_row_rdy;
    exp_fs = (phase == 3);
    exp_ir = rel_cnt > 0 && qs.size() == 0 && phase == 0;
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("wr_en", 32'(wr_en), 32'(exp_wr));
    if (exp_wr) begin
      w = qw.pop_front();
      chk("wr_col", 32'(wr_col_addr), w.col);
      chk("wr_data", 32'(wr_data), w.data);
      chk("sof_err", 32'(sof_err), 32'(w.err));
    end else chk("sof_err", 32'(sof_err), 0);
    chk("row_store", 32'(wr_row_store), 32'(exp_st));
    chk("row_swap", 32'(wr_row_swap), 32'(exp_st));
    chk("frame_swap", 32'(frame_swap), 32'(exp_fs));
    chk("frame_done", 32'(frame_done), 32'(exp_fs));
    if (wr_row_store) begin nst++; busy = 5; end
    if (frame_swap) nfs++;
    if (sof_err) nse++;
    if (exp_fs) phase = 0;
    else if (phase == 1) phase = 2;
    else if (phase == 2 && wr_row_rdy) phase = 3;
    if (exp_st) begin
      ln = qs.pop_front();
      chk("bank", 32'(wr_bank_addr), ln / NR);
      chk("row", 32'(wr_row_addr), ln % NR);
      if (ln == NL - 1) phase = 1;
    end
    if (in_valid && in_ready) begin
      err = in_sof && (m_col != 0 || m_line != 0);
      if (err) begin m_col = 0; m_line = 0; end
      qw.push_back('{m_col, int'(in_data), err});
      m_col++;
      if (m_col == NC) begin
        m_col = 0;
        qs.push_back(m_line);
        m_line = (m_line + 1) % NL;
      end
      accepted = 1;
    end
    rel_cnt++;
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    ncyc++;
    if (busy > 0) begin wr_row_rdy = 1'b0; busy--; end
    else wr_row_rdy = !hold;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("rst_pulses", 32'({wr_row_store, wr_row_swap, frame_swap, frame_done}), 0);
      if (i > 0)
        chk("rst_outs", 32'({in_ready, wr_en, sof_err, wr_data, wr_col_addr,
                             wr_bank_addr, wr_row_addr}), 0);
      @(posedge clk);
      #1;
      ncyc++;
    end
    rst_n = 1'b1;
    qw.delete(); qs.delete();
    m_col = 0; m_line = 0; phase = 0; rel_cnt = 0; busy = 0;
    wr_row_rdy = !hold;
  endtask

  // base >= 0 gives an incrementing data pattern, otherwise random data
  task automatic send(input int n, input int sof_a, input int sof_b, input int pct, input int base);
    int k;
    for (int i = 0; i < n; i++) begin
      in_data = (base >= 0) ? BD'(base + i) : BD'($urandom);
      in_sof  = (i == sof_a) || (i == sof_b);
      k = 0;
      do begin
        in_valid = int'($urandom_range(99)) < pct;
        cyc();
        k++;
      end while (!accepted && k < 500);
      if (!accepted) begin
        nchk++; nerr++;
        $display("FAIL accept_timeout: got none want pixel %0d accepted", i);
        break;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((qs.size() > 0 || qw.size() > 0 || phase != 0) && k < 400) begin
      cyc();
      k++;
    end
    if (k >= 400) begin
      nchk++; nerr++;
      $display("FAIL drain_timeout: got %0d pending lines want 0", qs.size());
    end
    repeat (3) cyc();
  endtask

  initial begin
    vt[0] = '{8,   0, -1, 100, 1,  0, 0};
    vt[1] = '{64,  0, -1, 100, 8,  1, 0};
    vt[2] = '{128, 0, -1, 60,  16, 2, 0};
    vt[3] = '{29,  0, 21, 100, 3,  0, 1};
    vt[4] = '{16,  0, 8,  70,  2,  0, 1};
    vt[5] = '{72,  0, 64, 100, 9,  1, 0};
    vt[6] = '{40, -1, -1, 50,  5,  0, 0};

    nchk = 0; nerr = 0; ncyc = 0; hold = 0; busy = 0;
    nst = 0; nfs = 0; nse = 0;
    rst_n = 1'b0; in_valid = 1'b1; in_sof = 1'b0; in_data = '0; wr_row_rdy = 1'b1;

    // Reset with valid asserted; ready must come up one cycle after release
    do_reset(3);
    in_valid = 1'b0;
    cyc();
    cyc();

    // Single line, incrementing data, store two cycles after last accept
    nst = 0;
    send(8, 0, -1, 100, 'h0100);
    drain();
    chk("single_stores", nst, 1);

    // Back-pressure: store held off while rdy is low
    nst = 0; hold = 1;
    send(8, -1, -1, 100, -1);
    repeat (10) cyc();
    chk("bp_held_stores", nst, 0);
    hold = 0;
    drain();
    chk("bp_stores", nst, 1);

    // Scenario table
    for (int v = 0; v < 7; v++) begin
      do_reset(2);
      nst = 0; nfs = 0; nse = 0;
      send(vt[v].npix, vt[v].sof_a, vt[v].sof_b, vt[v].pct, -1);
      drain();
      chk($sformatf("vec%0d_stores", v), nst, vt[v].st);
      chk($sformatf("vec%0d_fswaps", v), nfs, vt[v].fs);
      chk($sformatf("vec%0d_soferrs", v), nse, vt[v].se);
    end

    // Reset in line 5 col 3: no pulses, restart at origin
    do_reset(2);
    send(43, 0, -1, 100, -1);
    do_reset(2);
    nst = 0; nfs = 0; nse = 0;
    send(8, -1, -1, 100, -1);
    drain();
    chk("midrst_stores", nst, 1);
    chk("midrst_soferrs", nse, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/hub75_fb_feeder.md
# hub75_fb_feeder

Streaming pixel source adapter that drives the write side of the HUB75 frame buffer. It accepts raster-ordered pixels on a valid/ready stream and writes each line into the frame buffer's row buffer. At each line end it requests the row swap and store, and at frame end it issues the frame swap once the last store has drained. It sits between any pixel generator (pattern engine, video decoder, SPI loader) and the frame buffer write interface.

## Interface
Parameters:
- `N_BANKS`, 2: panel banks; power of 2.
- `N_ROWS`, 32: rows per bank; power of 2.
- `N_COLS`, 64: columns per row; power of 2.
- `BITDEPTH`, 24: pixel width.
- `LOG_N_BANKS` / `LOG_N_ROWS` / `LOG_N_COLS`: auto-set, `$clog2` of the above.

Ports:
- `clk` in 1: single clock. One clock; reset is synchronous and active-low.
- `rst_n` in 1: synchronous active-low reset.
- `in_data` in BITDEPTH: pixel.
- `in_valid` in 1: pixel valid.
- `in_ready` out 1: pixel accepted when `in_valid & in_ready`.
- `in_sof` in 1: qualifies the accepted pixel as the first pixel of a frame.
- `wr_bank_addr` out LOG_N_BANKS: bank of the line being stored.
- `wr_row_addr` out LOG_N_ROWS: row of the line being stored.
- `wr_row_store` out 1: store request pulse.
- `wr_row_rdy` in 1: frame buffer store engine idle.
- `wr_row_swap` out 1: row buffer swap pulse.
- `wr_data` out BITDEPTH: row buffer write data.
- `wr_col_addr` out LOG_N_COLS: row buffer write column.
- `wr_en` out 1: row buffer write strobe.
- `frame_swap` out 1: frame buffer swap pulse.
- `frame_done` out 1: pulse, coincident with `frame_swap`.
- `sof_err` out 1: pulse on frame resync.

## Operation
- Counters: `col` (LOG_N_COLS bits) and `line` (LOG_N_BANKS+LOG_N_ROWS bits). Bank is `line[MSBs]`, row is `line[LSBs]`. Both wrap naturally at their maximum.
- FSM states: FILL, WAIT_RDY, SETTLE, FLUSH, FSWAP.
- FILL: `in_ready`=1. On each accept, register `wr_data`/`wr_col_addr=col`/`wr_en` and increment `col`. On accept with `col==N_COLS-1`, go to WAIT_RDY.
- WAIT_RDY: `in_ready`=0.
  - Swap/store is never issued in the same cycle as `wr_en`.
  - When there is no pending write and `wr_row_rdy`=1, pulse `wr_row_swap` and `wr_row_store` together for 1 cycle, with bank/row from `line`.
  - Then increment `line`. If `line` was the last line, go to SETTLE; otherwise go to FILL.
- SETTLE: 1 cycle, during which `wr_row_rdy` is ignored. Then go to FLUSH.
- FLUSH: wait for `wr_row_rdy`=1, then go to FSWAP.
- FSWAP: pulse `frame_swap` and `frame_done` for 1 cycle, then go to FILL.
- SOF resync: an accepted pixel with `in_sof`=1 while (`col`,`line`)≠(0,0):
  - pulse `sof_err`;
  - discard the partial line (no swap/store);
  - reset `line`=0, `col`=0;
  - write the pixel as column 0 of line 0.
- Pixel at (0,0) without `in_sof`: accepted normally, no error.
- Address outputs hold their value between store pulses.

## Timing
- Reset values: `in_ready`=0 and all other outputs 0. FSM enters FILL and counters clear.
- `in_ready` is registered. It becomes 1 on the first cycle after `rst_n` rises.
- Accept at cycle t gives `wr_en` at t+1 (latency 1).
- Last pixel of a line accepted at t:
  - `in_ready`=0 from t+1;
  - earliest swap/store at t+2;
  - `in_ready`=1 on the cycle after the swap pulse.
- Last line: after the store pulse at s, SETTLE at s+1, FLUSH from s+2, `frame_swap` on the cycle after `wr_row_rdy`=1 is seen in FLUSH.
- Throughput: 1 pixel/cycle within a line. Minimum 2 idle cycles per line.
- Reset asserted mid-operation:
  - next edge returns every output and state to reset values;
  - any in-flight line is dropped;
  - no pulses are emitted.

## Structure
- Shared package (`hub75_pkg`): FSM state encodings (FILL/WAIT_RDY/SETTLE/FLUSH/FSWAP) and the derived-width helpers, reused by other frame buffer write-side blocks.
- No sub-module. Counters and FSM are inline; target size is about 150–250 lines.

## Test plan
Configuration: N_BANKS=2, N_ROWS=4, N_COLS=8, BITDEPTH=16, `wr_row_rdy` model going low for 5 cycles after each store unless stated.
- Reset: hold `rst_n`=0 for 3 cycles with `in_valid`=1. Required: all outputs 0 and `in_ready`=0. After release, `in_ready`=1 one cycle later.
- Single line: 8 back-to-back pixels 0x0100..0x0107 with `in_sof` on the first, `wr_row_rdy`=1. Required: `wr_en` on 8 consecutive cycles with columns 0..7 and matching data, then `wr_row_swap`+`wr_row_store` 2 cycles after the last accept with bank 0, row 0.
- Back-pressure: `wr_row_rdy`=0 for 10 cycles at line end. Required: `in_ready` stays 0 and the swap fires on the first cycle `wr_row_rdy`=1 is seen.
- Full frame: 64 pixels. Required:
  - 8 stores, in order (bank, row) = (0,0..3) then (1,0..3);
  - a single `frame_swap`/`frame_done` pulse only after `wr_row_rdy` returns high following the 8th store;
  - a second frame repeats the same sequence.
- SOF resync: `in_sof` on the pixel at col 5 of line 2. Required: `sof_err` pulses, no store for the partial line, that pixel is written at col 0, and the next store is bank 0, row 0.
- Mid-frame reset: reset during line 5 at col 3. Required: no swap/store/frame_swap pulses, and the next frame starts at bank 0, row 0, col 0.
